word_stacker_param: RTL and testbench



---
 rtl/word_stacker_param.sv | 123 ++++++++++++
 tb/tb_word_stacker_param.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/word_stacker_param.sv
// word_stacker_param: packs RATIO narrow input beats into one wide word.
// A beat with last_i closes the word early as a partial word with a lane count.
// Closed words are queued in an OUT_DEPTH-entry output FIFO.
module word_stacker_param #(
  parameter int IN_W      = 32,
  parameter int RATIO     = 4,
  parameter int MSB_FIRST = 0,
  parameter int OUT_DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  input  logic                         enable_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [IN_W-1:0]              word_i,
  input  logic                         last_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [IN_W*RATIO-1:0]        word_o,
  output logic [$clog2(RATIO+1)-1:0]   lanes_o,
  output logic                         last_o
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int LW    = $clog2(RATIO + 1);
  localparam int CW    = $clog2(RATIO);
  localparam int PW    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int NW    = $clog2(OUT_DEPTH + 1);

  logic [CW-1:0]    cnt_q;
  logic [OUT_W-1:0] acc_q;
  logic [OUT_W-1:0] merged;
  logic [CW-1:0]    lane_sel;

  logic [OUT_W-1:0] fifo_word  [OUT_DEPTH];
  logic [LW-1:0]    fifo_lanes [OUT_DEPTH];
  logic             fifo_last  [OUT_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [NW-1:0]    occ_q, occ_nxt;

  logic sync_clr, fifo_empty, fifo_full;
  logic accept, beat_done, push, pop;

  // Pointer advance that wraps at OUT_DEPTH, so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign sync_clr   = rst_i | clr_i;
  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == NW'(OUT_DEPTH));

  // ready_o depends only on registered occupancy, never on valid_i/last_i.
  assign ready_o   = enable_i & ~fifo_full & ~sync_clr;
  assign valid_o   = enable_i & ~fifo_empty;
  assign accept    = valid_i & ready_o;
  assign pop       = valid_o & ready_i;
  assign beat_done = (cnt_q == CW'(RATIO - 1)) | last_i;
  assign push      = accept & beat_done;

  assign word_o  = fifo_empty ? '0 : fifo_word[rd_ptr_q];
  assign lanes_o = fifo_empty ? '0 : fifo_lanes[rd_ptr_q];
  assign last_o  = fifo_empty ? 1'b0 : fifo_last[rd_ptr_q];

  // Lane selection and merge of the incoming beat into the accumulator.
  always_comb begin
    lane_sel = (MSB_FIRST != 0) ? (CW'(RATIO - 1) - cnt_q) : cnt_q;
    merged   = acc_q;
    for (int l = 0; l < RATIO; l++) begin
      if (int'(lane_sel) == l) merged[l*IN_W +: IN_W] = word_i;
    end
  end

  // Lane counter and accumulator; both clear when a word closes.
  always_ff @(posedge clk_i) begin
    if (sync_clr) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else if (accept) begin
      if (beat_done) begin
        cnt_q <= '0;
        acc_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
        acc_q <= merged;
      end
    end
  end

  // FIFO occupancy: simultaneous push and pop leaves it unchanged.
  always_comb begin
    occ_nxt = occ_q;
    case ({push, pop})
      2'b10:   occ_nxt = occ_q + NW'(1);
      2'b01:   occ_nxt = occ_q - NW'(1);
      default: occ_nxt = occ_q;
    endcase
  end

  // FIFO pointers and occupancy; reset/clear drops any queued words.
  always_ff @(posedge clk_i) begin
    if (sync_clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      occ_q <= occ_nxt;
    end
  end

  // FIFO storage; push is already blocked during reset/clear via ready_o.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_word[wr_ptr_q]  <= merged;
      fifo_lanes[wr_ptr_q] <= LW'(cnt_q) + LW'(1);
      fifo_last[wr_ptr_q]  <= last_i;
    end
  end

endmodule

// File: tb/tb_word_stacker_param.sv
// Bench for word_stacker_param: three instances share stimulus
// (defaults, MSB_FIRST=1, and IN_W=8/RATIO=3/OUT_DEPTH=3); a per-instance
// reference model queues expected words, compared when the DUT presents them.
module tb_word_stacker_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr, en, vin, lst, rdy;
  logic [31:0] win;

  logic         r0, v0, la0, r1, v1, la1, r2, v2, la2;
  logic [127:0] w0, w1;
  logic [23:0]  w2;
  logic [2:0]   l0, l1;
  logic [1:0]   l2;

  word_stacker_param #(.IN_W(32), .RATIO(4), .MSB_FIRST(0), .OUT_DEPTH(2)) dut0 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .enable_i(en), .valid_i(vin), .ready_o(r0),
    .word_i(win), .last_i(lst), .valid_o(v0), .ready_i(rdy), .word_o(w0), .lanes_o(l0),
    .last_o(la0));
  word_stacker_param #(.IN_W(32), .RATIO(4), .MSB_FIRST(1), .OUT_DEPTH(2)) dut1 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .enable_i(en), .valid_i(vin), .ready_o(r1),
    .word_i(win), .last_i(lst), .valid_o(v1), .ready_i(rdy), .word_o(w1), .lanes_o(l1),
    .last_o(la1));
  word_stacker_param #(.IN_W(8), .RATIO(3), .MSB_FIRST(0), .OUT_DEPTH(3)) dut2 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .enable_i(en), .valid_i(vin), .ready_o(r2),
    .word_i(win[7:0]), .last_i(lst), .valid_o(v2), .ready_i(rdy), .word_o(w2), .lanes_o(l2),
    .last_o(la2));

  logic [127:0] o_w [3];
  logic [2:0]   o_l [3];
  logic         o_v [3], o_r [3], o_la [3];
  assign o_w[0] = w0;  assign o_w[1] = w1;  assign o_w[2] = {104'b0, w2};
  assign o_l[0] = l0;  assign o_l[1] = l1;  assign o_l[2] = {1'b0, l2};
  assign o_v[0] = v0;  assign o_v[1] = v1;  assign o_v[2] = v2;
  assign o_r[0] = r0;  assign o_r[1] = r1;  assign o_r[2] = r2;
  assign o_la[0] = la0; assign o_la[1] = la1; assign o_la[2] = la2;

  int P_W [3] = '{32, 32, 8};
  int P_R [3] = '{4, 4, 3};
  int P_M [3] = '{0, 1, 0};
  int P_D [3] = '{2, 2, 3};

  typedef struct packed {
    logic [127:0] w;
    logic [2:0]   lanes;
    logic         last;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int           m_cnt [3];
  int           m_occ [3];
  logic [127:0] m_acc [3];
  bit           m_took [3];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic q_push(input int i, input exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic q_pop(input int i);
    case (i)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic q_clear(input int i);
    case (i)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endtask

  function automatic exp_t q_head(input int i);
    case (i)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  // Reference model step for the edge just taken, using the inputs held across it.
  task automatic model_update();
    exp_t         e;
    bit           do_pop;
    int           lane;
    logic [127:0] beat;
    for (int i = 0; i < 3; i++) begin
      m_took[i] = 1'b0;
      if (rst || clr) begin
        m_cnt[i] = 0; m_acc[i] = '0; m_occ[i] = 0; q_clear(i);
      end else if (en) begin
        do_pop = (m_occ[i] > 0) && rdy;
        if (vin && (m_occ[i] < P_D[i])) begin
          m_took[i] = 1'b1;
          lane = (P_M[i] != 0) ? (P_R[i] - 1 - m_cnt[i]) : m_cnt[i];
          beat = (P_W[i] == 32) ? {96'b0, win} : {120'b0, win[7:0]};
          m_acc[i] = m_acc[i] | (beat << (lane * P_W[i]));
          if ((m_cnt[i] == P_R[i] - 1) || lst) begin
            e.w = m_acc[i]; e.lanes = 3'(m_cnt[i] + 1); e.last = lst;
            q_push(i, e);
            m_occ[i]++;
            m_acc[i] = '0; m_cnt[i] = 0;
          end else begin
            m_cnt[i]++;
          end
        end
        if (do_pop) begin
          q_pop(i);
          m_occ[i]--;
        end
      end
    end
  endtask

  task automatic check_all();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("valid_o[%0d]", i), 128'(o_v[i]), 128'(en && (m_occ[i] > 0)));
      chk($sformatf("ready_o[%0d]", i), 128'(o_r[i]),
          128'(en && !rst && !clr && (m_occ[i] < P_D[i])));
      if (en && (m_occ[i] > 0)) begin
        e = q_head(i);
        chk($sformatf("word_o[%0d]", i), o_w[i], e.w);
        chk($sformatf("lanes_o[%0d]", i), 128'(o_l[i]), 128'(e.lanes));
        chk($sformatf("last_o[%0d]", i), 128'(o_la[i]), 128'(e.last));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic beat(input logic [31:0] w, input logic l);
    vin = 1'b1; win = w; lst = l;
    tick();
  endtask

  int guard;

  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b1; vin = 1'b0; lst = 1'b0; rdy = 1'b1; win = '0;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_occ[i] = 0; m_acc[i] = '0; m_took[i] = 1'b0;
    end
    tick(); tick();
    chk("rst_valid", 128'(v0), 128'(0));
    chk("rst_ready", 128'(r0), 128'(0));
    chk("rst_word", w0, 128'(0));
    chk("rst_lanes", 128'(l0), 128'(0));
    chk("rst_last", 128'(la0), 128'(0));
    rst = 1'b0;
    tick();

    // Full word, LSB-first and MSB-first lane order.
    beat(32'hAAAAAAAA, 1'b0);
    beat(32'hBBBBBBBB, 1'b0);
    beat(32'h12345678, 1'b0);
    beat(32'h55555555, 1'b0);
    chk("t1_word", w0, 128'h55555555_12345678_BBBBBBBB_AAAAAAAA);
    chk("t1_lanes", 128'(l0), 128'(4));
    chk("t2_word", w1, 128'hAAAAAAAA_BBBBBBBB_12345678_55555555);
    vin = 1'b0; tick(); tick();

    // Partial flush on last_i.
    beat(32'h11111111, 1'b0);
    beat(32'h22222222, 1'b1);
    chk("t3_word", w0, 128'h00000000_00000000_22222222_11111111);
    chk("t3_lanes", 128'(l0), 128'(2));
    chk("t3_last", 128'(la0), 128'(1));
    vin = 1'b0; lst = 1'b0; tick(); tick();

    // Back-pressure: FIFO fills, ready_o drops, then drains in order.
    rdy = 1'b0;
    for (int b = 0; b < 8; b++) beat(32'hC0000000 + 32'(b), 1'b0);
    chk("t4_full_ready", 128'(r0), 128'(0));
    vin = 1'b1; win = 32'hC0000008;
    tick(); tick(); tick();
    chk("t4_hold_ready", 128'(r0), 128'(0));
    rdy = 1'b1;
    tick();
    chk("t4_ready_after_pop", 128'(r0), 128'(1));
    for (int b = 8; b < 12; b++) begin
      vin = 1'b1; win = 32'hC0000000 + 32'(b); lst = 1'b0;
      guard = 0;
      tick();
      while (!m_took[0] && guard < 10) begin
        tick();
        guard++;
      end
      chk("t4_beat_timeout", 128'(guard < 10), 128'(1));
    end
    vin = 1'b0;
    repeat (6) tick();

    // Enable gap in the middle of a word.
    beat(32'hE1E1E1E1, 1'b0);
    beat(32'hE2E2E2E2, 1'b0);
    en = 1'b0; win = 32'hE3E3E3E3;
    repeat (5) tick();
    chk("t5_dis_valid", 128'(v0), 128'(0));
    chk("t5_dis_ready", 128'(r0), 128'(0));
    en = 1'b1;
    beat(32'hE3E3E3E3, 1'b0);
    beat(32'hE4E4E4E4, 1'b0);
    chk("t5_word", w0, 128'hE4E4E4E4_E3E3E3E3_E2E2E2E2_E1E1E1E1);
    vin = 1'b0; tick(); tick();

    // Soft clear mid-packet discards the partial word.
    beat(32'h33333333, 1'b0);
    beat(32'h33333333, 1'b0);
    beat(32'h33333333, 1'b0);
    vin = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    for (int b = 0; b < 4; b++) beat(32'hFFFFFFFF, 1'b0);
    chk("t6_word", w0, {128{1'b1}});

    // Single-beat packet closed by last_i.
    beat(32'h77777777, 1'b1);
    chk("t7_word", w0, 128'h00000000_00000000_00000000_77777777);
    chk("t7_lanes", 128'(l0), 128'(1));
    vin = 1'b0; lst = 1'b0;
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
